// File: rtl/axis_uart_tx.sv
// AXI-stream byte sink that buffers bytes in a small FIFO and sends them as 8N1 UART frames,
// optionally following each tlast byte with a line-feed frame.
module axis_uart_tx #(
  parameter int DIVISOR   = 868,
  parameter int FIFO_AW   = 4,
  parameter bit APPEND_LF = 1'b0
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [7:0] i_tdata,
  input  logic       i_tlast,
  input  logic       i_tvalid,
  output logic       o_tready,
  output logic       o_uart_tx
);

  localparam int          DEPTH       = 1 << FIFO_AW;
  localparam logic [15:0] BAUD_RELOAD = 16'(DIVISOR - 1);
  localparam logic [7:0]  LF_BYTE     = 8'h0A;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_START   = 3'd1,
    ST_DATA    = 3'd2,
    ST_STOP    = 3'd3,
    ST_LF_PEND = 3'd4
  } state_t;

  logic [8:0]         fifo_mem_r [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr_r;
  logic [FIFO_AW-1:0] rd_ptr_r;
  logic [FIFO_AW:0]   count_r;

  state_t      state_r;
  logic [15:0] baud_cnt_r;
  logic [7:0]  shift_r;
  logic [2:0]  bit_idx_r;
  logic        last_r;
  logic        is_lf_r;
  logic        tx_r;

  logic       push_s;
  logic       pop_s;
  logic       empty_s;
  logic       full_s;
  logic       bit_end_s;
  logic       lf_due_s;
  logic [8:0] head_s;

  // Count never exceeds DEPTH, so its MSB alone flags a full FIFO.
  assign empty_s   = (count_r == '0);
  assign full_s    = count_r[FIFO_AW];
  assign o_tready  = !full_s && !i_rst;
  assign push_s    = i_tvalid && o_tready;
  assign head_s    = fifo_mem_r[rd_ptr_r];
  assign bit_end_s = (baud_cnt_r == 16'd0);
  assign lf_due_s  = (APPEND_LF == 1'b1) && last_r && !is_lf_r;
  assign o_uart_tx = tx_r;

  // Pop decision: idle start, or back-to-back reload when a stop bit expires.
  always_comb begin
    pop_s = 1'b0;
    if (i_rst) begin
      pop_s = 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: pop_s = !empty_s;
        ST_STOP: pop_s = bit_end_s && !lf_due_s && !empty_s;
        default: pop_s = 1'b0;
      endcase
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (push_s) wr_ptr_r <= wr_ptr_r + 1'b1;
      if (pop_s)  rd_ptr_r <= rd_ptr_r + 1'b1;
      if (push_s && !pop_s)      count_r <= count_r + 1'b1;
      else if (!push_s && pop_s) count_r <= count_r - 1'b1;
      else                       count_r <= count_r;
    end
  end

  // FIFO storage; contents are don't-care until written.
  always_ff @(posedge i_clk) begin
    if (push_s) fifo_mem_r[wr_ptr_r] <= {i_tlast, i_tdata};
  end

  // Transmit FSM with registered line output.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_r    <= ST_IDLE;
      baud_cnt_r <= 16'd0;
      shift_r    <= 8'd0;
      bit_idx_r  <= 3'd0;
      last_r     <= 1'b0;
      is_lf_r    <= 1'b0;
      tx_r       <= 1'b1;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (pop_s) begin
            state_r    <= ST_START;
            baud_cnt_r <= BAUD_RELOAD;
            shift_r    <= head_s[7:0];
            last_r     <= head_s[8];
            is_lf_r    <= 1'b0;
            tx_r       <= 1'b0;
          end
        end
        ST_START: begin
          if (bit_end_s) begin
            state_r    <= ST_DATA;
            baud_cnt_r <= BAUD_RELOAD;
            bit_idx_r  <= 3'd0;
            tx_r       <= shift_r[0];
          end else begin
            baud_cnt_r <= baud_cnt_r - 16'd1;
          end
        end
        ST_DATA: begin
          if (bit_end_s) begin
            baud_cnt_r <= BAUD_RELOAD;
            if (bit_idx_r == 3'd7) begin
              state_r <= ST_STOP;
              tx_r    <= 1'b1;
            end else begin
              bit_idx_r <= bit_idx_r + 3'd1;
              shift_r   <= {1'b0, shift_r[7:1]};
              tx_r      <= shift_r[1];
            end
          end else begin
            baud_cnt_r <= baud_cnt_r - 16'd1;
          end
        end
        ST_STOP: begin
          if (bit_end_s) begin
            baud_cnt_r <= BAUD_RELOAD;
            // The line-feed load is folded into this edge so the LF frame follows with no gap.
            if (lf_due_s) begin
              state_r <= ST_START;
              shift_r <= LF_BYTE;
              last_r  <= 1'b0;
              is_lf_r <= 1'b1;
              tx_r    <= 1'b0;
            end else if (pop_s) begin
              state_r <= ST_START;
              shift_r <= head_s[7:0];
              last_r  <= head_s[8];
              is_lf_r <= 1'b0;
              tx_r    <= 1'b0;
            end else begin
              state_r <= ST_IDLE;
              tx_r    <= 1'b1;
            end
          end else begin
            baud_cnt_r <= baud_cnt_r - 16'd1;
          end
        end
        ST_LF_PEND: begin
          state_r    <= ST_START;
          baud_cnt_r <= BAUD_RELOAD;
          shift_r    <= LF_BYTE;
          last_r     <= 1'b0;
          is_lf_r    <= 1'b1;
          tx_r       <= 1'b0;
        end
        default: begin
          state_r    <= ST_IDLE;
          baud_cnt_r <= 16'd0;
          tx_r       <= 1'b1;
        end
      endcase
    end
  end

endmodule
